// File: rtl/present80_enc_core_if.sv
// Host-side bus of the PRESENT-80 encryption core.
// The host drives the request; the core returns status and result.
interface present80_enc_core_if;
    logic        start;
    logic [63:0] plaintext;
    logic [79:0] key;
    logic        busy;
    logic        done;
    logic [63:0] ciphertext;

    modport master (output start, plaintext, key, input busy, done, ciphertext);
    modport slave  (input start, plaintext, key, output busy, done, ciphertext);
endinterface

// File: rtl/present80_enc_core.sv
// Iterative PRESENT-80 encryption: one full round (addRoundKey, sLayer, pLayer)
// per clock, with final key whitening in a separate FINAL cycle.

// PRESENT bit permutation: bit i moves to i*size/4 mod (size-1), MSB fixed.
module PLayer #(
    parameter int size = 64
) (
    input  logic [size-1:0] original,
    output logic [size-1:0] permuted
);
    for (genvar i = 0; i < size - 1; i++) begin : g_perm
        assign permuted[(i * (size / 4)) % (size - 1)] = original[i];
    end
    assign permuted[size-1] = original[size-1];
endmodule

module present80_enc_core #(
    parameter int ROUNDS = 31
) (
    input logic                  clk,
    input logic                  reset,
    present80_enc_core_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, RUN, FINAL} fsm_t;

    localparam logic [4:0] LAST_RC = 5'(ROUNDS);

    function automatic logic [3:0] sbox(input logic [3:0] x);
        case (x)
            4'h0: sbox = 4'hC;  4'h1: sbox = 4'h5;  4'h2: sbox = 4'h6;  4'h3: sbox = 4'hB;
            4'h4: sbox = 4'h9;  4'h5: sbox = 4'h0;  4'h6: sbox = 4'hA;  4'h7: sbox = 4'hD;
            4'h8: sbox = 4'h3;  4'h9: sbox = 4'hE;  4'hA: sbox = 4'hF;  4'hB: sbox = 4'h8;
            4'hC: sbox = 4'h4;  4'hD: sbox = 4'h7;  4'hE: sbox = 4'h1;  default: sbox = 4'h2;
        endcase
    endfunction

    fsm_t        fsm, fsm_next;
    logic [63:0] state;
    logic [79:0] kreg;
    logic [4:0]  rc;
    logic        done_q;
    logic [63:0] ct_q;
    logic        busy_c;

    logic [63:0] ark, sl_out, pl_out;
    logic [79:0] k_rot, k_next;

    // Round datapath: addRoundKey -> sLayer -> pLayer.
    assign ark = state ^ kreg[79:16];

    for (genvar n = 0; n < 16; n++) begin : g_slayer
        assign sl_out[4*n+3:4*n] = sbox(ark[4*n+3:4*n]);
    end

    PLayer #(.size(64)) u_player (
        .original (sl_out),
        .permuted (pl_out)
    );

    // Key schedule: rotate left 61, S-box top nibble, xor round counter.
    assign k_rot  = {kreg[18:0], kreg[79:19]};
    assign k_next = {sbox(k_rot[79:76]), k_rot[75:20], k_rot[19:15] ^ rc, k_rot[14:0]};

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            fsm <= IDLE;
        end else begin
            fsm <= fsm_next;
        end
    end

    // NOTE: a default assignment up front keeps this block purely combinational;
    // any path that skipped assigning fsm_next would infer a latch.
    always_comb begin
        fsm_next = fsm;
        case (fsm)
            IDLE:    if (bus.start) fsm_next = RUN;
            RUN:     if (rc == LAST_RC) fsm_next = FINAL;
            FINAL:   fsm_next = IDLE;
            default: fsm_next = IDLE;
        endcase
    end

    always_comb begin
        busy_c = (fsm != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= '0;
            kreg   <= '0;
            rc     <= '0;
            done_q <= 1'b0;
            ct_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (fsm)
                IDLE: begin
                    if (bus.start) begin
                        state <= bus.plaintext;
                        kreg  <= bus.key;
                        rc    <= 5'd1;
                    end
                end
                RUN: begin
                    state <= pl_out;
                    kreg  <= k_next;
                    rc    <= rc + 5'd1;
                end
                FINAL: begin
                    ct_q   <= ark;
                    done_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy       = busy_c;
    assign bus.done       = done_q;
    assign bus.ciphertext = ct_q;
endmodule

// File: tb/tb_present80_enc_core.sv
// Known-answer bench for present80_enc_core: table of published PRESENT-80
// vectors plus directed sequences for back-to-back, ignored start and abort.
module tb_present80_enc_core;
    typedef struct {
        logic [63:0] pt;
        logic [79:0] key;
        logic [63:0] ct;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;
    vec_t vecs [4];

    present80_enc_core_if bus ();

    present80_enc_core #(.ROUNDS(31)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Pulse start for one edge, then wait (bounded) for done.
    // lat = edges from accept to done; bcyc = cycles with busy high.
    task automatic run_op(input vec_t v, output int lat, output int bcyc, output logic [63:0] ct);
        @(negedge clk);
        bus.start = 1'b1;
        bus.plaintext = v.pt;
        bus.key = v.key;
        @(negedge clk);
        bus.start = 1'b0;
        lat = 1;
        bcyc = 0;
        while (!bus.done && lat < 100) begin
            if (bus.busy) bcyc++;
            @(negedge clk);
            lat++;
        end
        lat = lat - 1;
        ct = bus.ciphertext;
    endtask

    task automatic count_dones(input int cycles, output int cnt);
        cnt = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (bus.done) cnt++;
        end
    endtask

    initial begin
        int          lat, bcyc, t, nd, last, cnt;
        logic [63:0] ct;

        vecs[0] = '{64'h0000000000000000, 80'h00000000000000000000, 64'h5579C1387B228445};
        vecs[1] = '{64'h0000000000000000, 80'hFFFFFFFFFFFFFFFFFFFF, 64'hE72C46C0F5945049};
        vecs[2] = '{64'hFFFFFFFFFFFFFFFF, 80'h00000000000000000000, 64'hA112FFC72F68417B};
        vecs[3] = '{64'hFFFFFFFFFFFFFFFF, 80'hFFFFFFFFFFFFFFFFFFFF, 64'h3333DCD3213210D2};

        reset = 1'b1;
        bus.start = 1'b0;
        bus.plaintext = '0;
        bus.key = '0;
        repeat (2) @(negedge clk);
        check("reset busy", 80'(bus.busy), 80'd0);
        check("reset done", 80'(bus.done), 80'd0);
        check("reset ciphertext", 80'(bus.ciphertext), 80'd0);
        reset = 1'b0;

        // Known-answer table, one operation per vector.
        for (int i = 0; i < 4; i++) begin
            run_op(vecs[i], lat, bcyc, ct);
            check($sformatf("vec%0d latency", i), 80'(lat), 80'd32);
            check($sformatf("vec%0d busy cycles", i), 80'(bcyc), 80'd32);
            check($sformatf("vec%0d ciphertext", i), 80'(ct), 80'(vecs[i].ct));
            @(negedge clk);
            check($sformatf("vec%0d done pulse width", i), 80'(bus.done), 80'd0);
        end

        // start held high: back-to-back operations every 33 edges.
        @(negedge clk);
        bus.start = 1'b1;
        bus.plaintext = vecs[3].pt;
        bus.key = vecs[3].key;
        t = 0;
        nd = 0;
        last = 0;
        while (nd < 3 && t < 200) begin
            @(negedge clk);
            t++;
            if (bus.done) begin
                check($sformatf("stream%0d ciphertext", nd), 80'(bus.ciphertext), 80'(vecs[3].ct));
                check($sformatf("stream%0d period", nd), 80'(t - last), 80'd33);
                last = t;
                nd++;
                if (nd == 3) bus.start = 1'b0;
            end
        end
        check("stream done count", 80'(nd), 80'd3);
        repeat (2) @(negedge clk);
        check("stream idle after drop", 80'(bus.busy), 80'd0);

        // Second start at E10 with new inputs must be ignored.
        @(negedge clk);
        bus.start = 1'b1;
        bus.plaintext = vecs[0].pt;
        bus.key = vecs[0].key;
        t = 0;
        while (!bus.done && t < 100) begin
            @(negedge clk);
            t++;
            if (t == 1) bus.start = 1'b0;
            if (t == 5) check("ciphertext holds during run", 80'(bus.ciphertext), 80'(vecs[3].ct));
            if (t == 10) begin
                bus.start = 1'b1;
                bus.plaintext = vecs[2].pt;
                bus.key = vecs[2].key;
            end
            if (t == 11) bus.start = 1'b0;
        end
        check("ignored start latency", 80'(t - 1), 80'd32);
        check("ignored start ciphertext", 80'(bus.ciphertext), 80'(vecs[0].ct));
        count_dones(40, cnt);
        check("ignored start no second done", 80'(cnt), 80'd0);
        check("ciphertext holds when idle", 80'(bus.ciphertext), 80'(vecs[0].ct));

        // Reset at E15 aborts the operation.
        @(negedge clk);
        bus.start = 1'b1;
        bus.plaintext = vecs[1].pt;
        bus.key = vecs[1].key;
        for (t = 1; t <= 15; t++) begin
            @(negedge clk);
            if (t == 1) bus.start = 1'b0;
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort busy", 80'(bus.busy), 80'd0);
        check("abort done", 80'(bus.done), 80'd0);
        check("abort ciphertext", 80'(bus.ciphertext), 80'd0);
        count_dones(40, cnt);
        check("abort no done", 80'(cnt), 80'd0);

        run_op(vecs[1], lat, bcyc, ct);
        check("post-abort latency", 80'(lat), 80'd32);
        check("post-abort ciphertext", 80'(ct), 80'(vecs[1].ct));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/present80_enc_core.md
Name: present80_enc_core

Overview:
- Iterative PRESENT-80 encryption engine. Executes one full round per clock: addRoundKey, then sLayer, then pLayer.
- The pLayer step instantiates the existing PLayer block. Ports `.original` and `.permuted` are 64 bits wide (`size` = 64).
- This block is the sequential stage wrapped around PLayer. It supplies PLayer's input and consumes its output.
- Sits between the host/test harness and downstream ciphertext consumers. It is also the block used for known-answer checks of the whole datapath.

Parameters:
ROUNDS, 31, number of full rounds before final key whitening (only 31 is a supported configuration; other values are for debug only)

Ports:
clk  in  1  system clock, rising-edge
reset  in  1  synchronous, active-high reset
start  in  1  request encryption; sampled only when idle
plaintext  in  64  input block; sampled on the accepting edge
key  in  80  cipher key; sampled on the accepting edge
busy  out  1  high while an encryption is in progress
done  out  1  one-cycle pulse; ciphertext valid in the same cycle
ciphertext  out  64  result register; holds value until the next done

Behaviour:
- Reset is synchronous, active-high, and has priority over everything.
  - Resets: fsm to IDLE; busy, done, ciphertext, state register and round counter rc to 0; key register to 0.
- Reset asserted mid-operation aborts the operation. No done is produced. Outputs follow the reset values above.
- FSM states: IDLE, RUN, FINAL.
- IDLE:
  - On start=1 at edge E0: state <= plaintext; kreg <= key; rc <= 1; go to RUN; busy <= 1.
  - On start=0: remain in IDLE.
- RUN (one edge per round):
  - state <= PLayer(S(state ^ kreg[79:16])).
  - kreg <= update(kreg, rc).
  - rc <= rc + 1 (5-bit counter).
  - If rc == ROUNDS, go to FINAL.
- Key update, in order:
  - Rotate left by 61: k <= {kreg[18:0], kreg[79:19]}.
  - k[79:76] <= S(k[79:76]).
  - k[19:15] <= k[19:15] ^ rc.
- FINAL:
  - ciphertext <= state ^ kreg[79:16]; done <= 1; busy <= 0; go to IDLE.
- done is a single-cycle pulse and is cleared on the next edge.
- Latency: start sampled at E0, rounds at E1..E31, ciphertext/done registered at E32.
  - done is high for exactly the cycle between E32 and E33.
  - busy is high between E0 and E32.
- S-box (4-bit, applied to all 16 nibbles of the state), input 0..F maps to output C,5,6,B,9,0,A,D,3,E,F,8,4,7,1,2.
- start while busy is ignored.
  - plaintext and key may change freely after E0 without affecting the result.
- start asserted in the cycle in which done=1 (fsm already IDLE) is accepted. This allows back-to-back operations with a 33-cycle period.
- ciphertext holds its value until the next FINAL or reset. It is not cleared when a new operation starts.
- rc never wraps: it is reloaded to 1 on each accept. The rc value after FINAL is don't-care.

Test Plan:
- Reset, then plaintext=0000000000000000, key=80'h0, start pulse -> done at E32, ciphertext=5579C1387B228445, busy high for exactly 32 cycles.
- plaintext=0, key=80'hFFFFFFFFFFFFFFFFFFFF -> ciphertext=E72C46C0F5945049; plaintext=FFFFFFFFFFFFFFFF, key=0 -> A112FFC72F68417B.
- plaintext=FFFFFFFFFFFFFFFF, key=all-ones -> 3333DCD3213210D2.
  - Hold start high continuously for this scenario.
  - Operations must repeat every 33 cycles, with done each time and identical ciphertext.
- Start vector 1; at E10 change plaintext/key and pulse start again.
  - The second start is ignored; done only at E32 with vector-1 result.
  - No second done follows.
- Start vector 1; assert reset at E15 for one cycle.
  - busy=0, done=0 and ciphertext=0 from the next cycle; no done ever appears for that operation.
  - A subsequent start with vector 2 yields the correct result 32 edges later.
- Stream the vectors from the cases memory file into the core, one per done.
  - Compare against the expected half of each vector.
  - Report the mismatch count; it must be 0.
